// File: rtl/load_extend_unit.sv
// load_extend_unit
//   Pulls the addressed byte, halfword, word or full word out of a memory data
//   word and sign- or zero-extends it to DATA_W bits. Results go through a
//   2-entry FIFO with valid/ready on both sides. A saturating counter records
//   accepted misaligned requests.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   in_valid   request present
//   in_ready   room for a request (registered state only)
//   in_data    raw memory word
//   in_off     byte offset of the access inside in_data
//   in_size    00 byte, 01 half, 10 word (32 b), 11 full DATA_W
//   in_sgn     1 sign-extend, 0 zero-extend
//   out_valid  FIFO head holds a result
//   out_ready  consumer takes the head
//   out_data   extended result at the head
//   out_err    head came from a misaligned request
//   err_cnt    saturating count of accepted misaligned requests
//   err_clr    clears err_cnt, wins over a same-cycle increment
module load_extend_unit #(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_sgn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
);

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic              err_q  [2];
    logic              err_d  [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] field_mask;
    logic              field_msb;
    logic              misaligned;
    logic [DATA_W-1:0] ext_data;
    logic              push;
    logic              pop;

    // Extraction: the field is isolated with a mask rather than a replication
    // so that sizes equal to DATA_W need no zero-width special case.
    always_comb begin
        lane       = in_data >> {in_off, 3'b000};
        field_mask = '1;
        field_msb  = 1'b0;
        misaligned = 1'b0;
        case (in_size)
            2'b00: begin
                field_mask = DATA_W'(8'hFF);
                field_msb  = lane[7];
            end
            2'b01: begin
                field_mask = DATA_W'(16'hFFFF);
                field_msb  = lane[15];
                misaligned = in_off[0];
            end
            2'b10: begin
                field_mask = DATA_W'(32'hFFFF_FFFF);
                field_msb  = lane[31];
                misaligned = |in_off[1:0];
            end
            default: begin
                field_mask = '1;
                field_msb  = 1'b0;
                misaligned = |in_off;
            end
        endcase

        if (misaligned) begin
            ext_data = '0;
        end else begin
            ext_data = (lane & field_mask) | ((in_sgn && field_msb) ? ~field_mask : '0);
        end
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_err   = err_q[rd_ptr_q];
    assign err_cnt   = err_cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        data_d   = data_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            data_d[wr_ptr_q] = ext_data;
            err_d[wr_ptr_q]  = misaligned;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (push && misaligned && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            err_q[0]  <= 1'b0;
            err_q[1]  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_load_extend_unit.sv
module tb_load_extend_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        in_valid_a, in_ready_a, in_sgn_a, out_valid_a, out_ready_a, out_err_a, err_clr_a;
    logic [31:0] in_data_a, out_data_a;
    logic [1:0]  in_off_a, in_size_a;
    logic [7:0]  err_cnt_a;

    logic        in_valid_b, in_ready_b, in_sgn_b, out_valid_b, out_ready_b, out_err_b, err_clr_b;
    logic [63:0] in_data_b, out_data_b;
    logic [2:0]  in_off_b;
    logic [1:0]  in_size_b;
    logic [7:0]  err_cnt_b;

    load_extend_unit #(.DATA_W(32), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .in_off(in_off_a), .in_size(in_size_a), .in_sgn(in_sgn_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_err(out_err_a), .err_cnt(err_cnt_a), .err_clr(err_clr_a)
    );

    load_extend_unit #(.DATA_W(64), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_off(in_off_b), .in_size(in_size_b), .in_sgn(in_sgn_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_err(out_err_b), .err_cnt(err_cnt_b), .err_clr(err_clr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_a    = 0;
    int cnt_b    = 0;

    logic [32:0] sb_a [$];
    logic [64:0] sb_b [$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitors: sample mid low phase, after the negedge drivers have settled.
    initial forever begin
        @(negedge clk);
        #2;
        if (out_valid_a) begin
            if (sb_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_a_unexpected: got data %h err %b with nothing expected", out_data_a, out_err_a);
            end else begin
                chk("out_a_data", 64'(out_data_a), 64'(sb_a[0][31:0]));
                chk("out_a_err", 64'(out_err_a), 64'(sb_a[0][32]));
                if (out_ready_a) void'(sb_a.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (out_valid_b) begin
            if (sb_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_b_unexpected: got data %h err %b with nothing expected", out_data_b, out_err_b);
            end else begin
                chk("out_b_data", out_data_b, sb_b[0][63:0]);
                chk("out_b_err", 64'(out_err_b), 64'(sb_b[0][64]));
                if (out_ready_b) void'(sb_b.pop_front());
            end
        end
    end

    // Drivers start and end at a negedge; the expected result is queued when
    // the request is seen to be accepted.
    task automatic send_a(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                          input logic sg, input logic [31:0] ed, input logic ee);
        in_valid_a = 1'b1; in_data_a = d; in_off_a = off; in_size_a = sz; in_sgn_a = sg;
        for (int i = 0; i < 50; i++) begin
            if (in_ready_a) begin
                sb_a.push_back({ee, ed});
                if (err_clr_a) cnt_a = 0;
                else if (ee && cnt_a != 255) cnt_a++;
                @(posedge clk);
                @(negedge clk);
                in_valid_a = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_a_timeout: got in_ready %b expected 1 within 50 cycles", in_ready_a);
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input logic sg, input logic [63:0] ed, input logic ee);
        in_valid_b = 1'b1; in_data_b = d; in_off_b = off; in_size_b = sz; in_sgn_b = sg;
        for (int i = 0; i < 50; i++) begin
            if (in_ready_b) begin
                sb_b.push_back({ee, ed});
                if (err_clr_b) cnt_b = 0;
                else if (ee && cnt_b != 255) cnt_b++;
                @(posedge clk);
                @(negedge clk);
                in_valid_b = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_b_timeout: got in_ready %b expected 1 within 50 cycles", in_ready_b);
        in_valid_b = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (sb_a.size() == 0 && sb_b.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain_a", 64'(sb_a.size()), 64'd0);
        chk("drain_b", 64'(sb_b.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid_a = 0; in_data_a = 0; in_off_a = 0; in_size_a = 0; in_sgn_a = 0;
        out_ready_a = 1; err_clr_a = 0;
        in_valid_b = 0; in_data_b = 0; in_off_b = 0; in_size_b = 0; in_sgn_b = 0;
        out_ready_b = 1; err_clr_b = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_out_data_a", 64'(out_data_a), 64'd0);
        chk("rst_out_err_a", 64'(out_err_a), 64'd0);
        chk("rst_err_cnt_a", 64'(err_cnt_a), 64'd0);
        chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_a", 64'(in_ready_a), 64'd1);
        chk("rst_in_ready_b", 64'(in_ready_b), 64'd1);

        // Extraction, 32-bit datapath
        send_a(32'h12F45678, 2'd2, 2'b00, 1'b1, 32'hFFFF_FFF4, 1'b0);
        chk("latency_out_valid_a", 64'(out_valid_a), 64'd1);
        send_a(32'h8001ABCD, 2'd2, 2'b01, 1'b0, 32'h0000_8001, 1'b0);
        send_a(32'h8001ABCD, 2'd2, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0);
        send_a(32'h80A1B2C3, 2'd3, 2'b00, 1'b0, 32'h0000_0080, 1'b0);
        send_a(32'h80A1B2C3, 2'd0, 2'b00, 1'b1, 32'hFFFF_FFC3, 1'b0);
        send_a(32'hCAFE7123, 2'd0, 2'b01, 1'b1, 32'h0000_7123, 1'b0);
        send_a(32'h89ABCDEF, 2'd0, 2'b10, 1'b0, 32'h89AB_CDEF, 1'b0);
        send_a(32'h89ABCDEF, 2'd0, 2'b11, 1'b1, 32'h89AB_CDEF, 1'b0);
        chk("err_cnt_a_aligned", 64'(err_cnt_a), 64'd0);

        // Misalignment and counter
        send_a(32'h12345678, 2'd1, 2'b10, 1'b0, 32'h0, 1'b1);
        chk("err_cnt_a_first", 64'(err_cnt_a), 64'd1);
        send_a(32'h12345678, 2'd1, 2'b01, 1'b1, 32'h0, 1'b1);
        send_a(32'h12345678, 2'd2, 2'b11, 1'b0, 32'h0, 1'b1);
        chk("err_cnt_a_three", 64'(err_cnt_a), 64'd3);
        for (int i = 0; i < 300; i++) send_a(32'hDEADBEEF, 2'd3, 2'b01, 1'b1, 32'h0, 1'b1);
        chk("err_cnt_a_saturate", 64'(err_cnt_a), 64'd255);
        err_clr_a = 1'b1;
        send_a(32'hDEADBEEF, 2'd2, 2'b10, 1'b0, 32'h0, 1'b1);
        err_clr_a = 1'b0;
        chk("err_cnt_a_clr_priority", 64'(err_cnt_a), 64'd0);
        send_a(32'hDEADBEEF, 2'd1, 2'b01, 1'b0, 32'h0, 1'b1);
        chk("err_cnt_a_after_clr", 64'(err_cnt_a), 64'd1);
        drain();

        // Backpressure: A and B fill the buffer, C must wait
        out_ready_a = 1'b0;
        send_a(32'h000000AA, 2'd0, 2'b00, 1'b1, 32'hFFFF_FFAA, 1'b0);
        send_a(32'h7FFF0000, 2'd2, 2'b01, 1'b1, 32'h0000_7FFF, 1'b0);
        in_valid_a = 1'b1; in_data_a = 32'h11223344; in_off_a = 2'd0; in_size_a = 2'b10; in_sgn_a = 1'b1;
        chk("full_in_ready_a_0", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        chk("full_in_ready_a_1", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        chk("full_in_ready_a_2", 64'(in_ready_a), 64'd0);
        out_ready_a = 1'b1;
        send_a(32'h11223344, 2'd0, 2'b10, 1'b1, 32'h1122_3344, 1'b0);
        drain();

        // Reset with two entries buffered
        out_ready_a = 1'b0;
        send_a(32'h0000ABCD, 2'd0, 2'b01, 1'b0, 32'h0000_ABCD, 1'b0);
        send_a(32'h0000ABCD, 2'd3, 2'b10, 1'b0, 32'h0, 1'b1);
        chk("prerst_err_cnt_a", 64'(err_cnt_a), 64'(cnt_a));
        reset = 1'b1;
        @(negedge clk);
        sb_a.delete();
        cnt_a = 0;
        chk("midrst_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("midrst_out_data_a", 64'(out_data_a), 64'd0);
        chk("midrst_err_cnt_a", 64'(err_cnt_a), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_a", 64'(in_ready_a), 64'd1);
        out_ready_a = 1'b1;
        repeat (5) @(negedge clk);
        send_a(32'h00FF0000, 2'd2, 2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0);
        drain();

        // 64-bit datapath
        send_b(64'h8000_0000_0000_0000, 3'd4, 2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_b(64'h8000_0000_0000_0000, 3'd4, 2'b10, 1'b0, 64'h0000_0000_8000_0000, 1'b0);
        send_b(64'h0123_4567_89AB_CDEF, 3'd0, 2'b11, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        send_b(64'h0123_4567_89AB_CDEF, 3'd4, 2'b11, 1'b0, 64'h0, 1'b1);
        chk("err_cnt_b_full_mis", 64'(err_cnt_b), 64'd1);
        send_b(64'h80FF_0000_0000_0000, 3'd7, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        send_b(64'h0000_8765_0000_0000, 3'd4, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_8765, 1'b0);
        send_b(64'h0000_8765_0000_0000, 3'd2, 2'b10, 1'b0, 64'h0, 1'b1);
        chk("err_cnt_b_word_mis", 64'(err_cnt_b), 64'd2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
